// File: rtl/hit_window_judge.sv
// Two-player rhythm timing judge: times each latched arrow pattern to the hit zone and
// grades rising key edges inside the acceptance window as perfect, good or miss.
module hit_window_judge #(
  parameter int unsigned TRAVEL   = 50_000_000,
  parameter int unsigned WIN_GOOD = 10_000_000,
  parameter int unsigned WIN_PERF = 2_500_000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       game_over,
  input  logic [7:0] pattern_out,
  input  logic       pattern_valid,
  input  logic [3:0] player_a_keys,
  input  logic [3:0] player_b_keys,
  output logic       perfect_hit_a,
  output logic       perfect_hit_b,
  output logic       good_hit_a,
  output logic       good_hit_b,
  output logic       miss_a,
  output logic       miss_b,
  output logic [7:0] combo_a,
  output logic [7:0] combo_b,
  output logic       busy_a,
  output logic       busy_b
);

  localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_WIN_START = CNT_W'(TRAVEL - WIN_GOOD);
  localparam logic [CNT_W-1:0] L_WIN_END   = CNT_W'(TRAVEL + WIN_GOOD);
  localparam logic [CNT_W-1:0] L_PERF_LO   = CNT_W'(TRAVEL - WIN_PERF);
  localparam logic [CNT_W-1:0] L_PERF_HI   = CNT_W'(TRAVEL + WIN_PERF);

  typedef enum logic [1:0] {StIdle, StTravel, StWindow} state_e;

  logic [7:0]      w_keys_all;
  logic [1:0]      w_perf, w_good, w_miss, w_busy;
  logic [1:0][7:0] w_combo;

  assign w_keys_all = {player_b_keys, player_a_keys};

  for (genvar g = 0; g < 2; g++) begin : g_judge
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_target, r_acc, r_keys_q;
    logic             r_perf, r_good, r_miss, r_busy;
    logic [7:0]       r_combo;

    logic [3:0] w_nib, w_keys, w_rise, w_acc;
    logic       w_load, w_late, w_wrong, w_hit, w_in_perf, w_judged;
    logic [7:0] w_combo_inc;

    assign w_nib       = pattern_out[4*g +: 4];
    assign w_keys      = w_keys_all[4*g +: 4];
    assign w_rise      = w_keys & ~r_keys_q;
    assign w_acc       = r_acc | w_rise;
    assign w_load      = pattern_valid && (w_nib != 4'd0);
    assign w_late      = r_cnt > L_WIN_END;
    assign w_wrong     = |(w_acc & ~r_target);
    assign w_hit       = (r_state == StWindow) && !w_late && !w_wrong && (w_acc == r_target);
    // Two one-sided compares give |cnt - TRAVEL| <= WIN_PERF without unsigned wrap
    assign w_in_perf   = (r_cnt >= L_PERF_LO) && (r_cnt <= L_PERF_HI);
    assign w_judged    = (r_state == StWindow) && (w_late || w_wrong || w_hit);
    assign w_combo_inc = (r_combo == 8'hFF) ? r_combo : r_combo + 8'd1;

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        r_state  <= StIdle;
        r_cnt    <= '0;
        r_target <= 4'd0;
        r_acc    <= 4'd0;
        r_keys_q <= 4'd0;
        r_perf   <= 1'b0;
        r_good   <= 1'b0;
        r_miss   <= 1'b0;
        r_busy   <= 1'b0;
        r_combo  <= 8'd0;
      end else begin
        r_keys_q <= w_keys;
        r_perf   <= 1'b0;
        r_good   <= 1'b0;
        r_miss   <= 1'b0;
        if (game_over) begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end else begin
          // A pending arrow displaced by a new pattern counts as a miss unless it hit now
          if (w_hit) begin
            r_perf  <= w_in_perf;
            r_good  <= !w_in_perf;
            r_combo <= w_combo_inc;
          end else if (w_judged || ((r_state != StIdle) && w_load)) begin
            r_miss  <= 1'b1;
            r_combo <= 8'd0;
          end

          if (w_load) begin
            r_target <= w_nib;
            r_cnt    <= '0;
            r_acc    <= 4'd0;
            r_state  <= StTravel;
            r_busy   <= 1'b1;
          end else begin
            case (r_state)
              StTravel: begin
                r_cnt <= r_cnt + L_ONE;
                if ((r_cnt + L_ONE) == L_WIN_START) r_state <= StWindow;
              end
              StWindow: begin
                if (w_judged) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
                end else begin
                  r_cnt <= r_cnt + L_ONE;
                  r_acc <= w_acc;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end

    assign w_perf[g]  = r_perf;
    assign w_good[g]  = r_good;
    assign w_miss[g]  = r_miss;
    assign w_busy[g]  = r_busy;
    assign w_combo[g] = r_combo;
  end

  assign perfect_hit_a = w_perf[0];
  assign perfect_hit_b = w_perf[1];
  assign good_hit_a    = w_good[0];
  assign good_hit_b    = w_good[1];
  assign miss_a        = w_miss[0];
  assign miss_b        = w_miss[1];
  assign busy_a        = w_busy[0];
  assign busy_b        = w_busy[1];
  assign combo_a       = w_combo[0];
  assign combo_b       = w_combo[1];

endmodule

// File: tb/tb_hit_window_judge.sv
// Directed bench for hit_window_judge with TRAVEL=20, WIN_GOOD=6, WIN_PERF=2, CNT_W=8.
module tb_hit_window_judge;

  logic       CLOCK_50 = 1'b0;
  logic       reset, game_over, pattern_valid;
  logic [7:0] pattern_out;
  logic [3:0] player_a_keys, player_b_keys;
  logic       perfect_hit_a, perfect_hit_b, good_hit_a, good_hit_b, miss_a, miss_b;
  logic       busy_a, busy_b;
  logic [7:0] combo_a, combo_b;

  int n_tests = 0;
  int n_fail  = 0;

  hit_window_judge #(
    .TRAVEL  (20),
    .WIN_GOOD(6),
    .WIN_PERF(2),
    .CNT_W   (8)
  ) u_dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .game_over    (game_over),
    .pattern_out  (pattern_out),
    .pattern_valid(pattern_valid),
    .player_a_keys(player_a_keys),
    .player_b_keys(player_b_keys),
    .perfect_hit_a(perfect_hit_a),
    .perfect_hit_b(perfect_hit_b),
    .good_hit_a   (good_hit_a),
    .good_hit_b   (good_hit_b),
    .miss_a       (miss_a),
    .miss_b       (miss_b),
    .combo_a      (combo_a),
    .combo_b      (combo_b),
    .busy_a       (busy_a),
    .busy_b       (busy_b)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {8'd0, perfect_hit_a, good_hit_a, miss_a, busy_a,
            perfect_hit_b, good_hit_b, miss_b, busy_b, combo_a, combo_b};
  endfunction

  // Strobe a pattern; returns in the cycle where the new counter reads 0
  task automatic strobe(input logic [7:0] pat);
    pattern_out   = pat;
    pattern_valid = 1'b1;
    tick();
    pattern_valid = 1'b0;
    pattern_out   = 8'h00;
  endtask

  // Full player A arrow: press nib when counter == c, report the graded pulses
  task automatic hit_a(input logic [3:0] nib, input int c, output logic p, output logic gd,
                       output logic m);
    strobe({4'h0, nib});
    repeat (c) tick();
    player_a_keys = nib;
    tick();
    p  = perfect_hit_a;
    gd = good_hit_a;
    m  = miss_a;
    player_a_keys = 4'd0;
    tick();
  endtask

  logic p, gd, m;
  int   n_miss, at, n_perf, n_pulse;

  initial begin
    reset         = 1'b1;
    game_over     = 1'b0;
    pattern_valid = 1'b0;
    pattern_out   = 8'h00;
    player_a_keys = 4'd0;
    player_b_keys = 4'd0;
    repeat (3) tick();
    check("reset_outputs", all_outs(), 32'd0);
    reset = 1'b0;
    tick();

    // Single arrow hit dead centre
    strobe(8'h01);
    check("busy_a_set", {30'd0, busy_a, busy_b}, 32'b10);
    repeat (20) tick();
    player_a_keys = 4'b0001;
    tick();
    check("s1_pulses_a", {29'd0, perfect_hit_a, good_hit_a, miss_a}, 32'b100);
    check("s1_combo_a", combo_a, 32'd1);
    check("s1_busy_a", busy_a, 32'd0);
    check("s1_b_quiet", {perfect_hit_b, good_hit_b, miss_b, busy_b, combo_b}, 32'd0);
    player_a_keys = 4'd0;
    tick();
    check("s1_one_cycle", perfect_hit_a, 32'd0);

    // Player B chord spread over two cycles
    strobe(8'h30);
    repeat (15) tick();
    player_b_keys = 4'b0001;
    tick();
    check("s2_partial", {good_hit_b, perfect_hit_b, miss_b}, 32'd0);
    player_b_keys = 4'b0011;
    tick();
    check("s2_pulses_b", {29'd0, perfect_hit_b, good_hit_b, miss_b}, 32'b010);
    check("s2_combo_b", combo_b, 32'd1);
    player_b_keys = 4'd0;
    tick();

    // Combo to 3, then travel-phase press ignored and wrong key misses
    hit_a(4'b0001, 20, p, gd, m);
    hit_a(4'b0001, 21, p, gd, m);
    check("s3_combo3", combo_a, 32'd3);
    strobe(8'h02);
    repeat (5) tick();
    player_a_keys = 4'b0001;
    tick();
    check("s3_travel_press", {30'd0, miss_a, busy_a}, 32'b01);
    player_a_keys = 4'd0;
    repeat (13) tick();
    player_a_keys = 4'b0100;
    tick();
    check("s3_wrong_key", {29'd0, perfect_hit_a, good_hit_a, miss_a}, 32'b001);
    check("s3_combo_clr", combo_a, 32'd0);
    player_a_keys = 4'd0;
    tick();

    // Timeout miss exactly once, in the cycle after counter 27
    strobe(8'h08);
    n_miss = 0;
    at     = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (miss_a) begin
        n_miss++;
        at = i;
      end
    end
    check("s4_timeout_cnt", n_miss, 32'd1);
    check("s4_timeout_at", at, 32'd28);

    // Combo saturation
    n_perf = 0;
    for (int i = 0; i < 300; i++) begin
      hit_a(4'b0001, 20, p, gd, m);
      if (p && !gd && !m) n_perf++;
    end
    check("s4_perf_cnt", n_perf, 32'd300);
    check("s4_combo_sat", combo_a, 32'd255);

    // New pattern displaces an unhit arrow
    strobe(8'h04);
    repeat (10) tick();
    pattern_out   = 8'h02;
    pattern_valid = 1'b1;
    tick();
    pattern_valid = 1'b0;
    pattern_out   = 8'h00;
    check("s5_displace_miss", {30'd0, miss_a, busy_a}, 32'b11);
    check("s5_displace_combo", combo_a, 32'd0);
    repeat (20) tick();
    player_a_keys = 4'b0010;
    tick();
    check("s5_new_target", {29'd0, perfect_hit_a, good_hit_a, miss_a}, 32'b100);
    player_a_keys = 4'd0;
    tick();

    // Hit coinciding with a new strobe: hit reported, new arrow loaded
    strobe(8'h01);
    repeat (19) tick();
    player_a_keys = 4'b0001;
    pattern_out   = 8'h02;
    pattern_valid = 1'b1;
    tick();
    pattern_valid = 1'b0;
    pattern_out   = 8'h00;
    player_a_keys = 4'd0;
    check("s5_coincide", {28'd0, perfect_hit_a, good_hit_a, miss_a, busy_a}, 32'b1001);
    repeat (14) tick();
    player_a_keys = 4'b0010;
    tick();
    check("s5_win_edge_lo", {29'd0, perfect_hit_a, good_hit_a, miss_a}, 32'b010);
    check("s5_combo", combo_a, 32'd3);
    player_a_keys = 4'd0;
    tick();

    // Press just before the window is ignored; last window cycle still grades good
    strobe(8'h01);
    repeat (13) tick();
    player_a_keys = 4'b0001;
    tick();
    check("s6_pre_window", {perfect_hit_a, good_hit_a, miss_a}, 32'd0);
    player_a_keys = 4'd0;
    repeat (12) tick();
    player_a_keys = 4'b0001;
    tick();
    check("s6_win_edge_hi", {29'd0, perfect_hit_a, good_hit_a, miss_a}, 32'b010);
    check("s6_combo", combo_a, 32'd4);
    player_a_keys = 4'd0;
    tick();

    // game_over mid-window
    strobe(8'h01);
    repeat (16) tick();
    game_over = 1'b1;
    tick();
    check("s7_go_busy", busy_a, 32'd0);
    n_pulse = 0;
    for (int i = 0; i < 10; i++) begin
      player_a_keys = (i == 3) ? 4'b0001 : 4'd0;
      pattern_valid = (i == 5);
      pattern_out   = (i == 5) ? 8'h11 : 8'h00;
      tick();
      n_pulse += int'(perfect_hit_a) + int'(good_hit_a) + int'(miss_a) + int'(busy_a)
               + int'(busy_b);
    end
    pattern_valid = 1'b0;
    pattern_out   = 8'h00;
    player_a_keys = 4'd0;
    check("s7_go_quiet", n_pulse, 32'd0);
    check("s7_go_combo", combo_a, 32'd4);
    game_over = 1'b0;
    tick();
    check("s7_go_idle", busy_a, 32'd0);

    // Reset mid-travel clears everything
    strobe(8'h11);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("s8_reset_mid", all_outs(), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
